anim_step_gen: RTL and testbench
================================

Name: anim_step_gen

Overview:
- Rate and frame sequencer for the seven-segment animation path.
- Runs entirely on the 50 MHz board clock and replaces the derived slow clock with a one-cycle tick strobe.
- Produces a wrapping frame index (0..FRAMES-1) that the downstream segment/anode decoder turns into a segment pattern.
- Supports run/hold, direction, a 4-way rate select and synchronous restart.

Parameters:
- DIV, 12500000, base tick period in clk cycles (4 Hz at 50 MHz); must be >= 4 and a multiple of 4.
- FRAMES, 6, number of animation frames; must be >= 2.
- CW, 26, prescaler width; must satisfy 2^CW > 2*DIV-1.
- FW, 3, frame index width; must satisfy 2^FW >= FRAMES.

Ports:
- clk  in  1  50 MHz board clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  1 = run, 0 = hold (prescaler and frame frozen).
- dir  in  1  0 = frame increments, 1 = frame decrements.
- rate_sel  in  2  period limit L: 00 = DIV, 01 = DIV/2, 10 = DIV/4, 11 = 2*DIV.
- restart  in  1  synchronous restart of prescaler and frame.
- tick  out  1  one-cycle strobe, once per period.
- frame  out  FW  current frame index.
- wrap  out  1  one-cycle strobe when frame wraps.

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- Reset (rst_n = 0 at a rising edge): prescaler = 0, frame = 0, tick = 0, wrap = 0. Reset has priority over every other input.
- Priority order: rst_n, then restart, then en.
- restart = 1 (with rst_n = 1):
  - prescaler = 0, frame = 0, tick = 0, wrap = 0.
  - en is ignored; no tick is issued in that cycle.
- en = 0 (no reset, no restart):
  - prescaler and frame hold their values.
  - tick = 0, wrap = 0.
- en = 1, prescaler < L-1: prescaler increments; tick = 0, wrap = 0.
- en = 1, prescaler >= L-1 (terminal edge):
  - prescaler = 0, tick = 1.
  - frame steps on this same edge, so tick is high in the first cycle that shows the new frame value.
- Tick spacing: with en held high, tick fires after exactly L enabled edges from prescaler = 0. Tick period is L cycles and tick duty is 1 cycle.
- Frame step with dir = 0: frame + 1. From FRAMES-1 it goes to 0 and wrap = 1 on that edge.
- Frame step with dir = 1: frame - 1. From 0 it goes to FRAMES-1 and wrap = 1 on that edge.
- wrap is only ever asserted together with tick.
- Changing rate_sel mid-period takes effect immediately, using the ">=" compare:
  - If the current prescaler value is already >= new L-1, the next enabled edge is a terminal edge.
  - The prescaler never overruns past the new limit.
- Changing dir mid-period: the new direction applies to the next frame step. There is no extra step and no wrap unless the boundary is actually crossed.
- Internal arithmetic: the prescaler limit is computed in CW bits (DIV/2 and DIV/4 as exact shifts, 2*DIV as a left shift). Frame arithmetic is modulo FRAMES, not modulo 2^FW. Frame never holds a value >= FRAMES.
- Hold then resume (en 1 -> 0 -> 1): the prescaler continues from its held value. Remaining cycles to the next tick equal L-1 minus the held value, plus 1.

Test Plan:
All scenarios use DIV = 8, FRAMES = 6.
- Reset release, en = 1, rate_sel = 00, dir = 0 -> first tick on the 8th enabled edge. Frames go 1,2,3,4,5,0 on successive ticks spaced 8 cycles. wrap is high only with the tick that gives frame = 0.
- dir = 1 from frame 0 -> next tick gives frame = 5 with wrap = 1, then 4, 3 with wrap = 0.
- rate_sel 01 / 10 / 11 -> tick periods of 4 / 2 / 16 cycles respectively.
- Switch 00 -> 10 when prescaler = 5 -> terminal on the next enabled edge: tick = 1, prescaler = 0. Then ticks every 2 cycles.
- en dropped for 10 cycles when prescaler = 3 -> tick, frame and prescaler frozen. After en returns, the tick arrives 5 enabled edges later.
- restart pulsed coincident with a terminal edge at frame 4 -> tick = 0, frame = 0, prescaler = 0. rst_n low mid-period gives all outputs 0 on the next edge; the next tick is again 8 edges after release.

Source files
------------

// File: rtl/anim_step_gen.sv
// anim_step_gen: tick-strobe rate and wrapping frame sequencer for the seven-segment animation
module anim_step_gen #(
    parameter int DIV    = 12500000,
    parameter int FRAMES = 6,
    parameter int CW     = 26,
    parameter int FW     = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          dir,
    input  logic [1:0]    rate_sel,
    input  logic          restart,
    output logic          tick,
    output logic [FW-1:0] frame,
    output logic          wrap
);
    localparam logic [CW-1:0] LIM_BASE = CW'(DIV);
    localparam logic [CW-1:0] LIM_HALF = LIM_BASE >> 1;
    localparam logic [CW-1:0] LIM_QTR  = LIM_BASE >> 2;
    localparam logic [CW-1:0] LIM_DBL  = LIM_BASE << 1;
    localparam logic [FW-1:0] LAST     = FW'(FRAMES - 1);

    logic [CW-1:0] pre;
    logic [CW-1:0] lim;
    logic          term;
    logic [FW-1:0] frame_nxt;
    logic          wrap_nxt;

    // period limit from rate select; ">=" compare keeps a mid-period rate drop from overrunning
    always_comb begin
        lim = rate_sel == 2'b00 ? LIM_BASE :
              rate_sel == 2'b01 ? LIM_HALF :
              rate_sel == 2'b10 ? LIM_QTR  : LIM_DBL;
        term = pre >= lim - CW'(1);
    end

    // next frame modulo FRAMES in the selected direction, flagging boundary crossings
    always_comb begin
        wrap_nxt  = dir ? frame == '0 : frame == LAST;
        frame_nxt = dir ? (wrap_nxt ? LAST : frame - FW'(1))
                        : (wrap_nxt ? '0   : frame + FW'(1));
    end

    // prescaler, frame and strobes; reset beats restart beats enable
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            pre   <= '0;
            frame <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (!en) begin
            tick <= 1'b0;
            wrap <= 1'b0;
        end else if (term) begin
            pre   <= '0;
            frame <= frame_nxt;
            tick  <= 1'b1;
            wrap  <= wrap_nxt;
        end else begin
            pre  <= pre + CW'(1);
            tick <= 1'b0;
            wrap <= 1'b0;
        end
    end
endmodule

// File: tb/tb_anim_step_gen.sv
// tb_anim_step_gen: scoreboard bench for anim_step_gen with DIV=8, FRAMES=6
module tb_anim_step_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] rate_sel = 2'b00;
    logic       restart = 1'b0;
    logic       tick;
    logic [2:0] frame;
    logic       wrap;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit done = 1'b0;

    typedef struct {
        int         at;
        logic [2:0] frame;
        logic       wrap;
    } exp_t;
    exp_t sb[$];

    anim_step_gen #(.DIV(8), .FRAMES(6), .CW(5), .FW(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .rate_sel(rate_sel),
        .restart(restart), .tick(tick), .frame(frame), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // edge counter used as the time base for expected tick positions
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic expect_tick(input int dt, input int f, input bit w);
        exp_t e;
        e.at = cyc + dt;
        e.frame = 3'(f);
        e.wrap = w;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // monitor: every tick must match the head of the scoreboard
    always @(negedge clk) begin
        if (!done) begin
            if (wrap && !tick) chk("wrap_without_tick", 1, 0);
            if (tick) begin
                if (sb.size() == 0) chk("unexpected_tick", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("tick_cycle", cyc, e.at);
                    chk("tick_frame", int'(frame), int'(e.frame));
                    chk("tick_wrap", int'(wrap), int'(e.wrap));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        step(2);
        chk("reset_tick", int'(tick), 0);
        chk("reset_frame", int'(frame), 0);
        chk("reset_wrap", int'(wrap), 0);
        rst_n = 1'b1;
        en = 1'b1;
        for (int i = 1; i <= 6; i++) expect_tick(8 * i, i % 6, i == 6);
        step(48);
        dir = 1'b1;
        expect_tick(8, 5, 1'b1);
        expect_tick(16, 4, 1'b0);
        expect_tick(24, 3, 1'b0);
        step(24);
        rate_sel = 2'b01;
        expect_tick(4, 2, 1'b0);
        expect_tick(8, 1, 1'b0);
        step(8);
        rate_sel = 2'b10;
        expect_tick(2, 0, 1'b0);
        expect_tick(4, 5, 1'b1);
        step(4);
        rate_sel = 2'b11;
        expect_tick(16, 4, 1'b0);
        step(16);
        dir = 1'b0;
        rate_sel = 2'b00;
        step(5);
        rate_sel = 2'b10;
        expect_tick(1, 5, 1'b0);
        expect_tick(3, 0, 1'b1);
        expect_tick(5, 1, 1'b0);
        step(5);
        rate_sel = 2'b00;
        step(3);
        en = 1'b0;
        step(10);
        chk("hold_frame", int'(frame), 1);
        chk("hold_tick", int'(tick), 0);
        en = 1'b1;
        expect_tick(5, 2, 1'b0);
        expect_tick(13, 3, 1'b0);
        step(13);
        expect_tick(8, 4, 1'b0);
        step(15);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("restart_tick", int'(tick), 0);
        chk("restart_frame", int'(frame), 0);
        step(3);
        rst_n = 1'b0;
        step(1);
        chk("midrst_tick", int'(tick), 0);
        chk("midrst_frame", int'(frame), 0);
        chk("midrst_wrap", int'(wrap), 0);
        rst_n = 1'b1;
        expect_tick(8, 1, 1'b0);
        step(12);
        en = 1'b0;
        step(2);
        chk("scoreboard_empty", sb.size(), 0);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
